// File: rtl/t21_stream_sink.sv
// t21_stream_sink
// Reader end of the T21 inter-node link. It terminates one node output port,
// returns a one-cycle ack per word and buffers the words in a show-ahead FIFO
// that the host drains.
//
// Optional feature macro: STREAM_SINK_RANGE_CHECK_EN
//   defined   : sticky range_err sets when a captured word is outside -999..999
//   undefined : range_err is tied low and no compare logic is built
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   up_in_data     word offered by the writer node (valid while up_in_ready=1)
//   up_in_ready    writer has a word pending
//   up_out_ready   registered ack pulse, high exactly one cycle per captured word
//   up_out_data    return data, constant 0
//   rd_en          host pop request
//   rd_data        FIFO head (show-ahead), 0 while empty
//   empty, full    FIFO occupancy flags, derived from count
//   count          words held, 0..DEPTH
//   range_err      sticky out-of-range flag
module t21_stream_sink #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        up_in_data,
    input  logic                     up_in_ready,
    output logic                     up_out_ready,
    output logic [DATA_W-1:0]        up_out_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     range_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ACK, RELEASE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    // Capture only from IDLE: a writer still holding ready after its ack
    // sits in RELEASE and cannot be captured twice.
    assign push        = (state == IDLE) && up_in_ready && !full;
    assign pop         = rd_en && !empty;
    assign up_out_data = '0;
    assign rd_data     = empty ? '0 : mem[rd_ptr];

    // Storage is not reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= up_in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            up_out_ready <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        state        <= ACK;
                        up_out_ready <= 1'b1;
                    end
                end
                ACK: begin
                    state        <= RELEASE;
                    up_out_ready <= 1'b0;
                end
                RELEASE: begin
                    if (!up_in_ready)
                        state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    up_out_ready <= 1'b0;
                end
            endcase

            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef STREAM_SINK_RANGE_CHECK_EN
    logic signed [31:0] din_ext;

    assign din_ext = 32'(signed'(up_in_data));

    always_ff @(posedge clk) begin
        if (reset)
            range_err <= 1'b0;
        else if (push && (din_ext > 32'sd999 || din_ext < -32'sd999))
            range_err <= 1'b1;
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_t21_stream_sink.sv
module tb_t21_stream_sink;

    localparam int DW    = 11;
    localparam int DEPTH = 16;

`ifdef STREAM_SINK_RANGE_CHECK_EN
    localparam logic RANGE_EXP = 1'b1;
`else
    localparam logic RANGE_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] up_in_data;
    logic          up_in_ready;
    logic          up_out_ready;
    logic [DW-1:0] up_out_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [4:0]    count;
    logic          range_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q[$];

    t21_stream_sink #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .up_in_data(up_in_data), .up_in_ready(up_in_ready),
        .up_out_ready(up_out_ready), .up_out_data(up_out_data),
        .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .range_err(range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted pop must present the oldest expected word.
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0d expected no word", rd_data);
            end else begin
                check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Offer one word, wait (bounded) for its ack, then release the link.
    task automatic push(input logic [DW-1:0] d);
        logic got;
        @(posedge clk); #1;
        up_in_data  = d;
        up_in_ready = 1'b1;
        exp_q.push_back(d);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (up_out_ready) got = 1'b1;
        end
        check("ack_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        up_in_ready = 1'b0;
        up_in_data  = '0;
    endtask

    task automatic pop_n(input int n);
        @(posedge clk); #1;
        rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        up_in_data  = '0;
        up_in_ready = 1'b0;
        rd_en       = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ack", 32'(up_out_ready), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        check("up_out_data", 32'(up_out_data), 32'd0);

        // Single word 42: ack exactly in cycle 1, writer then holds ready 5 cycles
        @(posedge clk); #1;
        up_in_data  = 11'd42;
        up_in_ready = 1'b1;
        exp_q.push_back(11'd42);
        @(negedge clk);
        check("ack_cycle0", 32'(up_out_ready), 32'd0);
        @(negedge clk);
        check("ack_cycle1", 32'(up_out_ready), 32'd1);
        check("single_count", 32'(count), 32'd1);
        check("single_rd_data", 32'(rd_data), 32'd42);
        check("single_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_no_reack", 32'(up_out_ready), 32'd0);
            check("hold_count", 32'(count), 32'd1);
        end
        @(posedge clk); #1;
        up_in_ready = 1'b0;
        pop_n(1);
        @(negedge clk);
        check("drain_count", 32'(count), 32'd0);

        // Fill to DEPTH, then a blocked 17th word
        for (int i = 1; i <= DEPTH; i++) push(DW'(i));
        @(negedge clk);
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd16);
        @(posedge clk); #1;
        up_in_data  = 11'h7FB;   // -5
        up_in_ready = 1'b1;
        exp_q.push_back(11'h7FB);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_no_ack", 32'(up_out_ready), 32'd0);
        end
        check("full_hold_count", 32'(count), 32'd16);
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        @(negedge clk);
        check("after_pop_count", 32'(count), 32'd15);
        check("after_pop_no_ack", 32'(up_out_ready), 32'd0);
        @(negedge clk);
        check("refill_ack", 32'(up_out_ready), 32'd1);
        check("refill_count", 32'(count), 32'd16);
        check("refill_full", 32'(full), 32'd1);
        @(posedge clk); #1 up_in_ready = 1'b0;

        // Drain to 3 words (15, 16, -5), then push and pop in the same cycle
        pop_n(13);
        @(negedge clk);
        check("count3", 32'(count), 32'd3);
        @(posedge clk); #1;
        up_in_data  = 11'd77;
        up_in_ready = 1'b1;
        rd_en       = 1'b1;
        exp_q.push_back(11'd77);
        @(posedge clk); #1 rd_en = 1'b0;
        @(negedge clk);
        check("pp_ack", 32'(up_out_ready), 32'd1);
        check("pp_count", 32'(count), 32'd3);
        check("pp_head", 32'(rd_data), 32'd16);
        @(posedge clk); #1 up_in_ready = 1'b0;
        repeat (2) @(posedge clk);
        pop_n(3);
        @(negedge clk);
        check("drained_empty", 32'(empty), 32'd1);

        // Reset asserted during the ACK cycle drops the ack and the word
        @(posedge clk); #1;
        up_in_data  = 11'd99;
        up_in_ready = 1'b1;
        @(posedge clk); #1;
        check("racy_ack", 32'(up_out_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset       = 1'b0;
        up_in_ready = 1'b0;
        @(negedge clk);
        check("rst_ack_dropped", 32'(up_out_ready), 32'd0);
        check("rst_ack_count", 32'(count), 32'd0);
        check("rst_ack_empty", 32'(empty), 32'd1);

        // Range flag
        push(11'h419);           // -999
        @(negedge clk);
        check("range_m999", 32'(range_err), 32'd0);
        push(11'd1000);
        @(negedge clk);
        check("range_1000", 32'(range_err), 32'(RANGE_EXP));
        push(11'd5);
        @(negedge clk);
        check("range_sticky", 32'(range_err), 32'(RANGE_EXP));
        check("range_count", 32'(count), 32'd3);
        pop_n(3);

        // Pop while empty is ignored
        pop_n(2);
        @(negedge clk);
        check("empty_pop_count", 32'(count), 32'd0);
        check("empty_pop_empty", 32'(empty), 32'd1);
        check("empty_pop_full", 32'(full), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
